mem_port_arbiter: RTL and testbench

Sequencer and arbiter that shares the single-port backing RAM between the instruction-cache refill path and the data-memory path of the pipelined core. Each requester holds a request until a one-cycle acknowledge; the block registers the winning address and write data onto the RAM port, counts out the fixed RAM read latency, and returns the read word with the acknowledge. One transaction is in flight at a time.

---
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port RAM between the instruction-refill requester and the
// data requester. One transaction is in flight at a time: IDLE picks a winner
// and registers its address/write data onto the RAM port, WAIT counts out the
// RAM read latency (or issues the single write strobe), DONE pulses the
// winner's acknowledge for one cycle.
//
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants on conflicting
// requests. Without it the data port wins every conflict.
//
// Handshake: a requester raises req with stable address/data and holds it
// until it sees its ack (a single-cycle pulse). It drops req on the edge that
// samples ack; req still high in the IDLE cycle after DONE is a new request.
// A losing req is not remembered and is simply re-evaluated in the next IDLE.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RAM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              owner,
    output logic [1:0]        o_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] LP_LAT = 3'(RAM_LAT);

    state_t            r_state;
    logic [2:0]        r_cnt;
    logic              r_owner;
    logic              r_tx_we;
    logic              r_i_ack;
    logic              r_d_ack;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_ram_we;
    logic [DATA_W-1:0] r_ram_wdata;
    logic              w_any_req;
    logic              w_grant_d;

    assign w_any_req = i_req | d_req;

`ifdef ARB_ROUND_ROBIN_EN
    // High when the next conflict goes to the data port (last grant was instruction).
    logic r_rr_fav_d;

    assign w_grant_d = d_req & (~i_req | r_rr_fav_d);

    // Round-robin pointer: moves to the other port on every grant.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_fav_d <= 1'b0;
        end else if (r_state == ST_IDLE && w_any_req) begin
            r_rr_fav_d <= ~w_grant_d;
        end
    end
`else
    // Fixed priority: the data access belongs to an older instruction.
    assign w_grant_d = d_req;
`endif

    // Transaction sequencer: grant, latency count, single-cycle acknowledge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 3'd0;
            r_owner     <= 1'b0;
            r_tx_we     <= 1'b0;
            r_i_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner    <= w_grant_d;
                        r_ram_addr <= w_grant_d ? d_addr : i_addr;
                        r_ram_we   <= w_grant_d & d_we;
                        r_tx_we    <= w_grant_d & d_we;
                        if (w_grant_d) begin
                            r_ram_wdata <= d_wdata;
                        end
                        r_cnt   <= LP_LAT;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_tx_we) begin
                        // Writes take one strobe cycle regardless of read latency.
                        r_ram_we <= 1'b0;
                        r_d_ack  <= 1'b1;
                        r_state  <= ST_DONE;
                    end else if (r_cnt == 3'd1) begin
                        if (r_owner) begin
                            r_d_rdata <= ram_rdata;
                            r_d_ack   <= 1'b1;
                        end else begin
                            r_i_rdata <= ram_rdata;
                            r_i_ack   <= 1'b1;
                        end
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                ST_DONE: begin
                    r_i_ack <= 1'b0;
                    r_d_ack <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign i_ack     = r_i_ack;
    assign d_ack     = r_d_ack;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign ram_addr  = r_ram_addr;
    assign ram_we    = r_ram_we;
    assign ram_wdata = r_ram_wdata;
    assign busy      = (r_state != ST_IDLE);
    assign owner     = r_owner;
    assign o_state   = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (read latency 1 and 4) driven
// independently, a transaction-timeline model checked every cycle, and
// directed scenarios with literal expectations.
module tb_mem_port_arbiter;

    localparam int LAT0 = 1;
    localparam int LAT1 = 4;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        i_req[2], d_req[2], d_we[2];
    logic [31:0] i_addr[2], d_addr[2], d_wdata[2], ram_rdata[2];
    logic        i_ack[2], d_ack[2], ram_we[2], busy[2], owner[2];
    logic [31:0] i_rdata[2], d_rdata[2], ram_addr[2], ram_wdata[2];
    logic [1:0]  st[2];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(LAT0)) u_lat1 (
        .clock(clock), .reset(reset),
        .i_req(i_req[0]), .i_addr(i_addr[0]), .i_ack(i_ack[0]), .i_rdata(i_rdata[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
        .d_ack(d_ack[0]), .d_rdata(d_rdata[0]),
        .ram_addr(ram_addr[0]), .ram_we(ram_we[0]), .ram_wdata(ram_wdata[0]),
        .ram_rdata(ram_rdata[0]), .busy(busy[0]), .owner(owner[0]), .o_state(st[0])
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(LAT1)) u_lat4 (
        .clock(clock), .reset(reset),
        .i_req(i_req[1]), .i_addr(i_addr[1]), .i_ack(i_ack[1]), .i_rdata(i_rdata[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
        .d_ack(d_ack[1]), .d_rdata(d_rdata[1]),
        .ram_addr(ram_addr[1]), .ram_we(ram_we[1]), .ram_wdata(ram_wdata[1]),
        .ram_rdata(ram_rdata[1]), .busy(busy[1]), .owner(owner[1]), .o_state(st[1])
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int we_cnt[2] = '{0, 0};
    logic [31:0] exp_q[$];

    task automatic chk_w(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d cyc %0d: got %h, want %h", name, k, cyc, act, exp);
        end
    endtask

    task automatic chk_b(input string name, input int k, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d cyc %0d: got %b, want %b", name, k, cyc, act, exp);
        end
    endtask

    task automatic timeout(input string name, input int k);
        n_cmp++;
        n_bad++;
        $display("FAIL %s inst%0d cyc %0d: no acknowledge within bound", name, k, cyc);
    endtask

    // RAM contents as a function of address.
    function automatic logic [31:0] ram_word(input logic [31:0] a);
        if (a == 32'h40) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // ---------------- behavioural model ----------------
    // A transaction granted out of idle cycle t0 occupies cycles t0+1..t0+end,
    // acknowledges in cycle t0+end, and the block is idle again at t0+end+1.
    int          lat[2] = '{LAT0, LAT1};
    bit          m_in_tx[2], m_own_d[2], m_we[2], m_owner[2], m_fav_d[2];
    int          m_t0[2];
    logic [31:0] m_addr[2], m_wdata[2], m_i_rdata[2], m_d_rdata[2];

    function automatic int tx_end(input int k);
        return m_we[k] ? 2 : lat[k] + 1;
    endfunction

    always @(posedge clock) begin
        cyc = cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_in_tx[k]   = 1'b0;
                m_addr[k]    = '0;
                m_owner[k]   = 1'b0;
                m_i_rdata[k] = '0;
                m_d_rdata[k] = '0;
                m_fav_d[k]   = 1'b0;
            end else begin
                if (m_in_tx[k] && !m_we[k] && (cyc - m_t0[k]) == tx_end(k)) begin
                    if (m_own_d[k]) m_d_rdata[k] = ram_word(m_addr[k]);
                    else            m_i_rdata[k] = ram_word(m_addr[k]);
                end
                if ((!m_in_tx[k] || (cyc - 1 - m_t0[k]) > tx_end(k)) && (i_req[k] || d_req[k])) begin
                    bit gd;
`ifdef ARB_ROUND_ROBIN_EN
                    gd = d_req[k] && (!i_req[k] || m_fav_d[k]);
`else
                    gd = d_req[k];
`endif
                    m_in_tx[k] = 1'b1;
                    m_t0[k]    = cyc - 1;
                    m_own_d[k] = gd;
                    m_owner[k] = gd;
                    m_we[k]    = gd && d_we[k];
                    m_addr[k]  = gd ? d_addr[k] : i_addr[k];
                    if (gd) m_wdata[k] = d_wdata[k];
                    m_fav_d[k] = !gd;
                end
            end
        end
    end

    // ---------------- per-cycle compare + RAM read-data drive ----------------
    initial begin : compare
        forever begin
            @(posedge clock);
            #1;
            for (int k = 0; k < 2; k++) begin
                int rel;
                bit act_tx, ex_busy, ex_iack, ex_dack, ex_we;
                rel     = cyc - m_t0[k];
                act_tx  = m_in_tx[k] && rel >= 1 && rel <= tx_end(k);
                ex_busy = act_tx;
                ex_iack = act_tx && rel == tx_end(k) && !m_own_d[k];
                ex_dack = act_tx && rel == tx_end(k) && m_own_d[k];
                ex_we   = act_tx && m_we[k] && rel == 1;
                chk_b("busy", k, busy[k], ex_busy);
                chk_b("i_ack", k, i_ack[k], ex_iack);
                chk_b("d_ack", k, d_ack[k], ex_dack);
                chk_b("dual_ack", k, i_ack[k] & d_ack[k], 1'b0);
                chk_b("ram_we", k, ram_we[k], ex_we);
                chk_b("owner", k, owner[k], m_owner[k]);
                chk_w("ram_addr", k, ram_addr[k], m_addr[k]);
                chk_w("i_rdata", k, i_rdata[k], m_i_rdata[k]);
                chk_w("d_rdata", k, d_rdata[k], m_d_rdata[k]);
                if (ex_we) chk_w("ram_wdata", k, ram_wdata[k], m_wdata[k]);
                // Valid word only in the last latency cycle of a read.
                if (act_tx && !m_we[k] && rel == lat[k]) ram_rdata[k] = ram_word(m_addr[k]);
                else                                    ram_rdata[k] = ~ram_word(m_addr[k]);
            end
        end
    end

    // Write strobe counter, sampled mid-cycle.
    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (ram_we[k] === 1'b1) we_cnt[k] = we_cnt[k] + 1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_req(input int k, input bit port_d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, output int c_req, output int c_ack);
        @(negedge clock);
        if (port_d) begin
            d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wdata;
        end else begin
            i_req[k] = 1'b1; i_addr[k] = addr;
        end
        c_req = cyc;
        c_ack = -1;
        for (int n = 0; n < 40 && c_ack < 0; n++) begin
            @(negedge clock);
            if (port_d ? d_ack[k] : i_ack[k]) c_ack = cyc;
        end
        if (port_d) d_req[k] = 1'b0;
        else        i_req[k] = 1'b0;
        if (c_ack < 0) timeout("do_req", k);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin : stim
        int c_req, c_ack, prev_ack, w0, ci, cd;
        logic [31:0] got;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            i_req[k] = 0; d_req[k] = 0; d_we[k] = 0;
            i_addr[k] = 0; d_addr[k] = 0; d_wdata[k] = 0; ram_rdata[k] = 0;
        end
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Reset then idle for ten cycles.
        chk_b("rst_busy", 0, busy[0], 1'b0);
        chk_w("rst_ram_wdata", 1, ram_wdata[1], 32'h0);
        w0 = we_cnt[0] + we_cnt[1];
        repeat (10) @(negedge clock);
        chk_w("idle_we_cnt", 0, 32'(we_cnt[0] + we_cnt[1] - w0), 32'd0);

        // Latency-1 instruction read of 0x40.
        do_req(0, 1'b0, 1'b0, 32'h40, 32'h0, c_req, c_ack);
        chk_w("lat1_iack_cycle", 0, 32'(c_ack - c_req), 32'd2);
        chk_w("lat1_i_rdata", 0, i_rdata[0], 32'h0050_0093);
        chk_w("lat1_ram_addr", 0, ram_addr[0], 32'h40);
        @(negedge clock);
        chk_b("lat1_busy_after", 0, busy[0], 1'b0);

        // Latency-1 data read and latency-4 instruction read.
        do_req(0, 1'b1, 1'b0, 32'h1234, 32'h0, c_req, c_ack);
        chk_w("lat1_dack_cycle", 0, 32'(c_ack - c_req), 32'd2);
        do_req(1, 1'b0, 1'b0, 32'h80, 32'h0, c_req, c_ack);
        chk_w("lat4_iack_cycle", 1, 32'(c_ack - c_req), 32'd5);

        // Latency-4: data read, then a write that must leave d_rdata alone.
        do_req(1, 1'b1, 1'b0, 32'h200, 32'h0, c_req, c_ack);
        w0 = we_cnt[1];
        do_req(1, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, c_req, c_ack);
        chk_w("wr_dack_cycle", 1, 32'(c_ack - c_req), 32'd2);
        chk_w("wr_d_rdata_kept", 1, d_rdata[1], ram_word(32'h200));
        chk_w("wr_we_pulses", 1, 32'(we_cnt[1] - w0), 32'd1);
        chk_w("wr_ram_wdata", 1, ram_wdata[1], 32'hDEAD_BEEF);

        // Conflicting requests held for three transactions each.
        pulse_reset();
`ifdef ARB_ROUND_ROBIN_EN
        exp_q = '{32'd0, 32'd1, 32'd0, 32'd1, 32'd0, 32'd1};
`else
        exp_q = '{32'd1, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0};
`endif
        @(negedge clock);
        i_req[0] = 1'b1; i_addr[0] = 32'h44;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h300;
        ci = 0; cd = 0;
        for (int n = 0; n < 200 && (ci < 3 || cd < 3); n++) begin
            @(negedge clock);
            if (i_ack[0] || d_ack[0]) begin
                got = d_ack[0] ? 32'd1 : 32'd0;
                if (d_ack[0]) begin cd++; if (cd == 3) d_req[0] = 1'b0; end
                else          begin ci++; if (ci == 3) i_req[0] = 1'b0; end
                if (exp_q.size() == 0) timeout("grant_extra", 0);
                else chk_w("grant_order", 0, got, exp_q.pop_front());
            end
        end
        i_req[0] = 1'b0; d_req[0] = 1'b0;
        if (ci < 3 || cd < 3) timeout("grant_loop", 0);

        // Reset during the wait of a latency-4 read; held request served afresh.
        @(negedge clock);
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h500;
        repeat (2) @(negedge clock);
        chk_b("pre_rst_busy", 1, busy[1], 1'b1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        c_req = cyc;
        chk_b("post_rst_busy", 1, busy[1], 1'b0);
        chk_b("post_rst_dack", 1, d_ack[1], 1'b0);
        c_ack = -1;
        for (int n = 0; n < 40 && c_ack < 0; n++) begin
            @(negedge clock);
            if (d_ack[1]) c_ack = cyc;
        end
        d_req[1] = 1'b0;
        if (c_ack < 0) timeout("rst_reissue", 1);
        else chk_w("rst_reissue_cycle", 1, 32'(c_ack - c_req), 32'd5);
        chk_w("rst_reissue_data", 1, d_rdata[1], ram_word(32'h500));

        // Back-to-back data reads on latency 4: acks six cycles apart.
        prev_ack = -1;
        for (int j = 0; j < 4; j++) begin
            do_req(1, 1'b1, 1'b0, 32'h600 + 32'(j * 4), 32'h0, c_req, c_ack);
            if (prev_ack >= 0) chk_w("b2b_spacing", 1, 32'(c_ack - prev_ack), 32'd6);
            prev_ack = c_ack;
        end

        repeat (4) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
